// File: rtl/y86_regfile_decode_stage.sv
// Y86-64 decode stage: register specifier decode, register file with two
// writeback ports (E, M) and optional same-cycle bypass, and a decode->execute
// pipeline register with valid/ready handshake.
module y86_regfile_decode_stage #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int RSP_IDX  = 4,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 icode,
  input  logic [3:0]                 rA,
  input  logic [3:0]                 rB,
  input  logic                       cnd,
  input  logic                       bubble,
  input  logic                       wbE_en,
  input  logic [3:0]                 wbE_dst,
  input  logic [DATA_W-1:0]          wbE_data,
  input  logic                       wbM_en,
  input  logic [3:0]                 wbM_dst,
  input  logic [DATA_W-1:0]          wbM_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_icode,
  output logic [DATA_W-1:0]          out_valA,
  output logic [DATA_W-1:0]          out_valB,
  output logic [3:0]                 out_srcA,
  output logic [3:0]                 out_srcB,
  output logic [3:0]                 out_dstE,
  output logic [3:0]                 out_dstM,
  output logic [NUM_REGS*DATA_W-1:0] reg_dump
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RSP    = RSP_IDX[3:0];
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_IRMV = 4'h3;
  localparam logic [3:0] I_RMMV = 4'h4;
  localparam logic [3:0] I_MRMV = 4'h5;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_PUSH = 4'hA;
  localparam logic [3:0] I_POP  = 4'hB;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] val_a, val_b;
  logic              e_ok, m_ok;

  // An ID names a real register only if it is not RNONE and is in range.
  function automatic logic id_ok(input logic [3:0] id);
    return (id != RNONE) && ({28'd0, id} < 32'(NUM_REGS));
  endfunction

  assign e_ok     = wbE_en && id_ok(wbE_dst);
  assign m_ok     = wbM_en && id_ok(wbM_dst);
  assign in_ready = out_ready | ~out_valid;

  // Operand read: M beats E beats the array when bypass is enabled.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    if (id_ok(id)) begin
      v = regs[id];
      if (BYPASS != 0) begin
        if (e_ok && wbE_dst == id) v = wbE_data;
        if (m_ok && wbM_dst == id) v = wbM_data;
      end
    end
    return v;
  endfunction

  // Register specifier decode from icode/rA/rB/cnd.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_CMOV: begin src_a = rA; dst_e = cnd ? rB : RNONE; end
      I_IRMV: dst_e = rB;
      I_RMMV: begin src_a = rA; src_b = rB; end
      I_MRMV: begin src_b = rB; dst_m = rA; end
      I_OPQ:  begin src_a = rA; src_b = rB; dst_e = rB; end
      I_CALL: begin src_b = RSP; dst_e = RSP; end
      I_RET:  begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSH: begin src_a = rA; src_b = RSP; dst_e = RSP; end
      I_POP:  begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = rA; end
      default: ;
    endcase
  end

  // Operand values for the instruction being decoded.
  always_comb begin
    val_a = read_port(src_a);
    val_b = read_port(src_b);
  end

  // Register file writes; M is issued last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (e_ok) regs[wbE_dst] <= wbE_data;
      if (m_ok) regs[wbM_dst] <= wbM_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
    assign reg_dump[g*DATA_W +: DATA_W] = regs[g];
  end

  // Decode->execute register: reset, bubble, load, or hold with operand refresh
  // so a stalled instruction never carries a stale operand into execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= 4'h0;
      out_valA  <= '0;
      out_valB  <= '0;
      out_srcA  <= RNONE;
      out_srcB  <= RNONE;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
    end else if (bubble) begin
      out_valid <= 1'b0;
      out_icode <= I_NOP;
      out_valA  <= '0;
      out_valB  <= '0;
      out_srcA  <= RNONE;
      out_srcB  <= RNONE;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_icode <= icode;
        out_valA  <= val_a;
        out_valB  <= val_b;
        out_srcA  <= src_a;
        out_srcB  <= src_b;
        out_dstE  <= dst_e;
        out_dstM  <= dst_m;
      end
    end else begin
      if (m_ok && wbM_dst == out_srcA)      out_valA <= wbM_data;
      else if (e_ok && wbE_dst == out_srcA) out_valA <= wbE_data;
      if (m_ok && wbM_dst == out_srcB)      out_valB <= wbM_data;
      else if (e_ok && wbE_dst == out_srcB) out_valB <= wbE_data;
    end
  end

endmodule

// File: tb/tb_y86_regfile_decode_stage.sv
// Bench for the Y86 decode stage: decode-table vectors, directed corner
// sequences and random traffic, all checked against a behavioural model.
module tb_y86_regfile_decode_stage;
  localparam int DW = 64;
  localparam int NR = 15;
  localparam logic [3:0] F = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, cnd, bubble, out_ready;
  logic [3:0] icode, rA, rB, wbE_dst, wbM_dst;
  logic wbE_en, wbM_en;
  logic [DW-1:0] wbE_data, wbM_data;
  logic out_valid;
  logic [3:0] out_icode, out_srcA, out_srcB, out_dstE, out_dstM;
  logic [DW-1:0] out_valA, out_valB;
  logic [NR*DW-1:0] reg_dump;
  // second instance without bypass
  logic in_ready_b0, out_valid_b0;
  logic [3:0] out_icode_b0, out_srcA_b0, out_srcB_b0, out_dstE_b0, out_dstM_b0;
  logic [DW-1:0] out_valA_b0, out_valB_b0;
  logic [NR*DW-1:0] reg_dump_b0;

  y86_regfile_decode_stage #(.DATA_W(DW), .NUM_REGS(NR), .RSP_IDX(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .bubble(bubble),
    .wbE_en(wbE_en), .wbE_dst(wbE_dst), .wbE_data(wbE_data),
    .wbM_en(wbM_en), .wbM_dst(wbM_dst), .wbM_data(wbM_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valA(out_valA), .out_valB(out_valB), .out_srcA(out_srcA), .out_srcB(out_srcB),
    .out_dstE(out_dstE), .out_dstM(out_dstM), .reg_dump(reg_dump));

  y86_regfile_decode_stage #(.DATA_W(DW), .NUM_REGS(NR), .RSP_IDX(4), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b0), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .bubble(bubble),
    .wbE_en(wbE_en), .wbE_dst(wbE_dst), .wbE_data(wbE_data),
    .wbM_en(wbM_en), .wbM_dst(wbM_dst), .wbM_data(wbM_data),
    .out_valid(out_valid_b0), .out_ready(out_ready), .out_icode(out_icode_b0),
    .out_valA(out_valA_b0), .out_valB(out_valB_b0), .out_srcA(out_srcA_b0), .out_srcB(out_srcB_b0),
    .out_dstE(out_dstE_b0), .out_dstM(out_dstM_b0), .reg_dump(reg_dump_b0));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // behavioural model: architectural registers plus the pipeline latch contents
  logic [63:0] mreg [NR];
  logic        mvalid;
  logic [3:0]  micode, msa, msb, mde, mdm;
  logic [63:0] mva, mvb;

  function automatic void ref_decode(input logic [3:0] ic, a, b, input logic c,
                                     output logic [3:0] sa, sb, de, dm);
    sa = F; sb = F; de = F; dm = F;
    case (ic)
      4'h2: begin sa = a; if (c) de = b; end
      4'h3: de = b;
      4'h4: begin sa = a; sb = b; end
      4'h5: begin sb = b; dm = a; end
      4'h6: begin sa = a; sb = b; de = b; end
      4'h8: begin sb = 4; de = 4; end
      4'h9: begin sa = 4; sb = 4; de = 4; end
      4'hA: begin sa = a; sb = 4; de = 4; end
      4'hB: begin sa = 4; sb = 4; de = 4; dm = a; end
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] ref_read(input logic [3:0] id);
    if (id >= NR) return 64'd0;
    if (wbM_en && wbM_dst == id) return wbM_data;
    if (wbE_en && wbE_dst == id) return wbE_data;
    return mreg[id];
  endfunction

  task automatic model_edge();
    logic [3:0] sa, sb, de, dm;
    if (rst) begin
      for (int i = 0; i < NR; i++) mreg[i] = 64'd0;
      mvalid = 0; micode = 0; mva = 0; mvb = 0;
      msa = F; msb = F; mde = F; mdm = F;
      return;
    end
    if (bubble) begin
      mvalid = 0; micode = 4'h1; msa = F; msb = F; mde = F; mdm = F;
    end else if (out_ready || !mvalid) begin
      mvalid = in_valid;
      if (in_valid) begin
        ref_decode(icode, rA, rB, cnd, sa, sb, de, dm);
        micode = icode; msa = sa; msb = sb; mde = de; mdm = dm;
        mva = ref_read(sa); mvb = ref_read(sb);
      end
    end else begin
      if (msa < NR) begin
        if (wbM_en && wbM_dst == msa) mva = wbM_data;
        else if (wbE_en && wbE_dst == msa) mva = wbE_data;
      end
      if (msb < NR) begin
        if (wbM_en && wbM_dst == msb) mvb = wbM_data;
        else if (wbE_en && wbE_dst == msb) mvb = wbE_data;
      end
    end
    if (wbE_en && wbE_dst < NR) mreg[wbE_dst] = wbE_data;
    if (wbM_en && wbM_dst < NR) mreg[wbM_dst] = wbM_data;
  endtask

  // one clock: check in_ready, advance model, then compare everything after the edge
  task automatic step();
    #1;
    if (!rst) chk("in_ready", in_ready, out_ready || !mvalid);
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mvalid);
    chk("out_icode", out_icode, micode);
    chk("out_srcA", out_srcA, msa);
    chk("out_srcB", out_srcB, msb);
    chk("out_dstE", out_dstE, mde);
    chk("out_dstM", out_dstM, mdm);
    if (mvalid) begin
      chk("out_valA", out_valA, mva);
      chk("out_valB", out_valB, mvb);
    end
    for (int i = 0; i < NR; i++) chk($sformatf("reg_dump[%0d]", i), reg_dump[i*DW +: DW], mreg[i]);
  endtask

  task automatic idle();
    in_valid = 0; bubble = 0; wbE_en = 0; wbM_en = 0; cnd = 0;
    icode = 0; rA = F; rB = F; wbE_dst = 0; wbM_dst = 0; wbE_data = 0; wbM_data = 0;
  endtask

  typedef struct {
    logic [3:0] ic, a, b;
    logic       c;
    logic [3:0] sa, sb, de, dm;
  } vec_t;
  vec_t tv [17];

  initial begin
    for (int i = 0; i < 16; i++) tv[i] = '{4'(i), 4'h1, 4'h2, 1'b1, F, F, F, F};
    tv[2]  = '{4'h2, 4'h1, 4'h2, 1'b1, 4'h1, F,    4'h2, F};
    tv[3]  = '{4'h3, 4'h1, 4'h2, 1'b1, F,    F,    4'h2, F};
    tv[4]  = '{4'h4, 4'h1, 4'h2, 1'b1, 4'h1, 4'h2, F,    F};
    tv[5]  = '{4'h5, 4'h1, 4'h2, 1'b1, F,    4'h2, F,    4'h1};
    tv[6]  = '{4'h6, 4'h1, 4'h2, 1'b1, 4'h1, 4'h2, 4'h2, F};
    tv[8]  = '{4'h8, 4'h1, 4'h2, 1'b1, F,    4'h4, 4'h4, F};
    tv[9]  = '{4'h9, 4'h1, 4'h2, 1'b1, 4'h4, 4'h4, 4'h4, F};
    tv[10] = '{4'hA, 4'h1, 4'h2, 1'b1, 4'h1, 4'h4, 4'h4, F};
    tv[11] = '{4'hB, 4'h1, 4'h2, 1'b1, 4'h4, 4'h4, 4'h4, 4'h1};
    tv[16] = '{4'h2, 4'h1, 4'h2, 1'b0, 4'h1, F,    F,    F};

    // reset with a pending writeback that must be discarded
    idle(); out_ready = 0; rst = 1;
    wbE_en = 1; wbE_dst = 4'h0; wbE_data = 64'h5;
    step(); step();
    chk("rst_dump", (reg_dump == '0), 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_dstE", out_dstE, F);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 0; idle(); out_ready = 1;

    // bypass: r3 written in the same cycle that OPq reads it
    in_valid = 1; icode = 4'h6; rA = 4'h3; rB = 4'h3;
    wbE_en = 1; wbE_dst = 4'h3; wbE_data = 64'h55;
    step();
    chk("byp_valA", out_valA, 64'h55);
    chk("byp_valB", out_valB, 64'h55);
    chk("byp_dstE", out_dstE, 4'h3);
    chk("nobyp_valA", out_valA_b0, 64'h0);
    chk("nobyp_valB", out_valB_b0, 64'h0);
    idle();

    // write collision: M wins
    wbE_en = 1; wbE_dst = 4'h4; wbE_data = 64'h10;
    wbM_en = 1; wbM_dst = 4'h4; wbM_data = 64'h20;
    step();
    chk("coll_r4", reg_dump[4*DW +: DW], 64'h20);
    idle();
    wbE_en = 1; wbE_dst = 4'h4; wbE_data = 64'h100;
    step(); idle();
    in_valid = 1; icode = 4'hB; rA = 4'h4; rB = F;
    step(); idle();
    chk("pop_valA", out_valA, 64'h100);
    chk("pop_valB", out_valB, 64'h100);
    chk("pop_dstE", out_dstE, 4'h4);
    chk("pop_dstM", out_dstM, 4'h4);

    // stall refresh on held mrmov
    in_valid = 1; icode = 4'h5; rA = 4'h1; rB = 4'h2;
    step();
    out_ready = 0; icode = 4'h6; rA = 4'h7; rB = 4'h8;
    wbM_en = 1; wbM_dst = 4'h2; wbM_data = 64'h99;
    step();
    chk("stall_valB", out_valB, 64'h99);
    chk("stall_icode", out_icode, 4'h5);
    chk("stall_srcB", out_srcB, 4'h2);
    chk("stall_dstM", out_dstM, 4'h1);
    chk("stall_in_ready", in_ready, 1'b0);
    idle();

    // bubble beats stall
    bubble = 1;
    step();
    chk("bub_valid", out_valid, 1'b0);
    chk("bub_icode", out_icode, 4'h1);
    chk("bub_srcA", out_srcA, F);
    chk("bub_dstE", out_dstE, F);
    idle(); out_ready = 1;

    // cmov condition
    in_valid = 1; icode = 4'h2; rA = 4'h1; rB = 4'h5; cnd = 0;
    step();
    chk("cmov0_dstE", out_dstE, F);
    cnd = 1;
    step();
    chk("cmov1_dstE", out_dstE, 4'h5);
    idle();

    // out-of-range write, RNONE read
    wbE_en = 1; wbE_dst = F; wbE_data = 64'hDEAD;
    in_valid = 1; icode = 4'h4; rA = F; rB = 4'h4;
    step();
    chk("oor_valA", out_valA, 64'h0);
    chk("oor_r4_kept", reg_dump[4*DW +: DW], 64'h100);
    idle();

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; icode = 4'h3; rA = F; rB = 4'(i);
      step();
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_dstE", out_dstE, 4'(i));
    end
    idle();

    // decode table
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; out_ready = 1;
      icode = tv[i].ic; rA = tv[i].a; rB = tv[i].b; cnd = tv[i].c;
      step();
      chk($sformatf("tbl%0d_srcA", i), out_srcA, tv[i].sa);
      chk($sformatf("tbl%0d_srcB", i), out_srcB, tv[i].sb);
      chk($sformatf("tbl%0d_dstE", i), out_dstE, tv[i].de);
      chk($sformatf("tbl%0d_dstM", i), out_dstM, tv[i].dm);
    end
    idle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      bubble    = ($urandom_range(0, 7) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      icode     = 4'($urandom_range(0, 15));
      rA        = 4'($urandom_range(0, 15));
      rB        = 4'($urandom_range(0, 15));
      cnd       = $urandom_range(0, 1);
      wbE_en    = $urandom_range(0, 1);
      wbE_dst   = 4'($urandom_range(0, 15));
      wbE_data  = {$urandom, $urandom};
      wbM_en    = $urandom_range(0, 1);
      wbM_dst   = 4'($urandom_range(0, 15));
      wbM_data  = {$urandom, $urandom};
      step();
    end
    rst = 0; idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
